// File: rtl/serial_frame_tx_if.sv
// Byte-in / serial-out signal bundle for serial_frame_tx.
// The producer drives in_data/in_valid; the transmitter drives the rest.
interface serial_frame_tx_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       serial_out;
   logic       busy;
   logic [3:0] bit_count;
   logic       done;

   modport master (
      output in_data, in_valid,
      input  in_ready, serial_out, busy, bit_count, done
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, serial_out, busy, bit_count, done
   );
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// A one-entry holding buffer allows back-to-back frames with no idle cycles between them.
module serial_frame_tx #(
   parameter int unsigned CLKS_PER_BIT = 1,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   serial_frame_tx_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   state_e      state_q,   state_d;
   logic [15:0] cnt_q,     cnt_d;
   logic [7:0]  shift_q,   shift_d;
   logic [7:0]  buf_q,     buf_d;
   logic        full_q,    full_d;
   logic        parity_q,  parity_d;
   logic        serial_q,  serial_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic        bit_end;
   logic        start_frame;

   assign bit_end = (cnt_q == LAST_CNT);

   always_comb begin
      // NOTE: every _d starts from its _q value so no path through this block infers a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      buf_d       = buf_q;
      full_d      = full_q;
      parity_d    = parity_q;
      serial_d    = serial_q;
      bit_cnt_d   = bit_cnt_q;
      start_frame = 1'b0;

      if (state_q != S_IDLE) begin
         cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            start_frame = full_q;
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               serial_d  = shift_q[0];
               bit_cnt_d = 4'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd9;
                  if (PARITY_EN) begin
                     state_d  = S_PARITY;
                     serial_d = parity_q;
                  end else begin
                     state_d  = S_STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  // Shift keeps the bit on the line at shift_q[0].
                  shift_d   = {1'b0, shift_q[7:1]};
                  serial_d  = shift_q[1];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d   = S_STOP;
               serial_d  = 1'b1;
               bit_cnt_d = 4'd10;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (full_q) begin
                  start_frame = 1'b1;
               end else begin
                  state_d   = S_IDLE;
                  serial_d  = 1'b1;
                  bit_cnt_d = 4'd0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (start_frame) begin
         state_d   = S_START;
         cnt_d     = 16'd0;
         shift_d   = buf_q;
         parity_d  = (^buf_q) ^ PARITY_ODD;
         full_d    = 1'b0;
         serial_d  = 1'b0;
         bit_cnt_d = 4'd0;
      end

      // Loading and accepting are exclusive: loading needs a full buffer, accepting an empty one.
      if (bus.in_valid && !full_q) begin
         buf_d  = bus.in_data;
         full_d = 1'b1;
      end
   end

   // NOTE: sequential state uses <= so every register samples the pre-edge value of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: buffer and shift register are cleared as well, so an aborted byte can never resurface.
         state_q   <= S_IDLE;
         cnt_q     <= 16'd0;
         shift_q   <= 8'd0;
         buf_q     <= 8'd0;
         full_q    <= 1'b0;
         parity_q  <= 1'b0;
         serial_q  <= 1'b1;
         bit_cnt_q <= 4'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         buf_q     <= buf_d;
         full_q    <= full_d;
         parity_q  <= parity_d;
         serial_q  <= serial_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bus.in_ready   = ~full_q;
   assign bus.serial_out = serial_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.bit_count  = bit_cnt_q;
   assign bus.done       = (state_q == S_STOP) && bit_end;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: three parameterisations share clock and reset,
// per-cycle vector tables plus a frame-decoding scoreboard on each serial line.
module tb_serial_frame_tx;

   typedef struct {
      logic       vld;
      logic [7:0] data;
      logic [7:0] exp;   // {serial_out, busy, done, bit_count[3:0], in_ready}
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       vld  [3];
   logic [7:0] data [3];
   logic       so   [3];
   logic       busy [3];
   logic       done [3];
   logic       rdy  [3];
   logic [3:0] bc   [3];

   int   n_tests = 0;
   int   n_fail  = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   serial_frame_tx_if if0 ();
   serial_frame_tx_if if1 ();
   serial_frame_tx_if if2 ();

   serial_frame_tx #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
      u_dut0 (.clk(clk), .reset(reset), .bus(if0));
   serial_frame_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
      u_dut1 (.clk(clk), .reset(reset), .bus(if1));
   serial_frame_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
      u_dut2 (.clk(clk), .reset(reset), .bus(if2));

   assign if0.in_valid = vld[0];
   assign if0.in_data  = data[0];
   assign if1.in_valid = vld[1];
   assign if1.in_data  = data[1];
   assign if2.in_valid = vld[2];
   assign if2.in_data  = data[2];

   assign so[0] = if0.serial_out;  assign busy[0] = if0.busy;  assign done[0] = if0.done;
   assign rdy[0] = if0.in_ready;   assign bc[0]   = if0.bit_count;
   assign so[1] = if1.serial_out;  assign busy[1] = if1.busy;  assign done[1] = if1.done;
   assign rdy[1] = if1.in_ready;   assign bc[1]   = if1.bit_count;
   assign so[2] = if2.serial_out;  assign busy[2] = if2.busy;  assign done[2] = if2.done;
   assign rdy[2] = if2.in_ready;   assign bc[2]   = if2.bit_count;

   // Level of frame bit b: start, data LSB first, optional parity, stop.
   function automatic logic fbit(logic [7:0] d, bit pe, bit po, int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (b == 9 && pe) return (^d) ^ po;
      return 1'b1;
   endfunction

   function automatic logic [7:0] pack_out(logic s, logic bz, logic dn, logic [3:0] c, logic r);
      return {s, bz, dn, c, r};
   endfunction

   function automatic logic [7:0] observe(int i);
      return {so[i], busy[i], done[i], bc[i], rdy[i]};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Row 0 transfers d; each following row is one clock of the frame, then one idle row.
   task automatic build_frame(logic [7:0] d, int cpb, bit pe, bit po);
      int   nb;
      vec_t r;
      nb = pe ? 11 : 10;
      vecs.delete();
      r.vld = 1'b1; r.data = d; r.exp = pack_out(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
      vecs.push_back(r);
      for (int b = 0; b < nb; b++) begin
         for (int c = 0; c < cpb; c++) begin
            r.vld  = 1'b0;
            r.data = ~d;
            r.exp  = pack_out(fbit(d, pe, po, b), 1'b1, (b == nb - 1 && c == cpb - 1), 4'(b), 1'b1);
            vecs.push_back(r);
         end
      end
      r.vld = 1'b0; r.data = ~d; r.exp = pack_out(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
      vecs.push_back(r);
   endtask

   task automatic apply_vecs(int idx, string tag);
      foreach (vecs[i]) begin
         vld[idx]  = vecs[i].vld;
         data[idx] = vecs[i].data;
         step();
         check($sformatf("%s_r%0d", tag, i), 32'(observe(idx)), 32'(vecs[i].exp));
      end
      vld[idx] = 1'b0;
   endtask

   // Scoreboard per line: bytes pushed when a handshake is seen, popped when a whole frame decodes.
   for (genvar g = 0; g < 3; g++) begin : gen_mon
      localparam int CPB = (g == 0) ? 1 : (g == 1) ? 4 : 2;
      localparam bit PE  = (g != 0);
      localparam bit PO  = (g == 2);
      localparam int NB  = PE ? 11 : 10;
      byte unsigned exp_q[$];
      int           frames   = 0;
      int           pos      = 0;
      bit           in_frame = 1'b0;
      logic [10:0]  bits     = '1;
      logic [10:0]  eb;
      byte unsigned e;

      always @(negedge clk) begin
         if (reset) begin
            in_frame = 1'b0;
            exp_q.delete();
         end else begin
            if (!in_frame && so[g] === 1'b0) begin
               in_frame = 1'b1;
               pos      = 0;
               bits     = '1;
            end
            if (in_frame) begin
               if (pos % CPB == 0) bits[pos / CPB] = so[g];
               if (pos == NB * CPB - 1) begin
                  in_frame = 1'b0;
                  frames++;
                  check($sformatf("sb%0d_pending", g), 32'(exp_q.size() != 0), 32'd1);
                  check($sformatf("sb%0d_done", g), 32'(done[g]), 32'd1);
                  if (exp_q.size() != 0) begin
                     e  = exp_q.pop_front();
                     eb = '1;
                     for (int b = 0; b < NB; b++) eb[b] = fbit(e, PE, PO, b);
                     check($sformatf("sb%0d_frame_%0d", g, frames), 32'(bits), 32'(eb));
                  end
               end else begin
                  pos++;
               end
            end
            if (vld[g] === 1'b1 && rdy[g] === 1'b1) exp_q.push_back(data[g]);
         end
      end
   end

   initial begin
      logic [7:0] exp_v;
      for (int i = 0; i < 3; i++) begin
         vld[i]  = 1'b0;
         data[i] = 8'h00;
      end
      reset = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 3; i++) check($sformatf("rst_state_%0d", i), 32'(observe(i)), 32'h81);
      reset = 1'b0;
      step();

      // 0xA5, 1 clock per bit, no parity.
      build_frame(8'hA5, 1, 1'b0, 1'b0);
      apply_vecs(0, "a5");

      // Held in_valid: 0x01 then 0x80 queued; second start bit right after first stop bit.
      vld[0] = 1'b1; data[0] = 8'h01;
      step();
      check("b2b_c0", 32'(observe(0)), 32'(pack_out(1'b1, 1'b0, 1'b0, 4'd0, 1'b0)));
      data[0] = 8'h80;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c <= 10)
            exp_v = pack_out(fbit(8'h01, 1'b0, 1'b0, c - 1), 1'b1, (c == 10), 4'(c - 1), (c == 1));
         else
            exp_v = pack_out(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
         check($sformatf("b2b_c%0d", c), 32'(observe(0)), 32'(exp_v));
         if (c == 2) vld[0] = 1'b0;
      end
      repeat (12) step();

      // Parity variants on the slower instances.
      build_frame(8'h07, 4, 1'b1, 1'b0);
      apply_vecs(1, "peven_07");
      build_frame(8'h07, 2, 1'b1, 1'b1);
      apply_vecs(2, "podd_07");
      build_frame(8'h00, 2, 1'b1, 1'b1);
      apply_vecs(2, "podd_00");

      // Continuous valid with changing data: only handshaken bytes may appear, in order.
      for (int i = 0; i < 80; i++) begin
         vld[0]  = 1'b1;
         data[0] = 8'($urandom);
         step();
      end
      vld[0] = 1'b0;
      repeat (25) step();

      // Asynchronous reset in the middle of data bit 4.
      vld[0] = 1'b1; data[0] = 8'h3C;
      step();
      vld[0] = 1'b0;
      repeat (5) step();
      check("mid_bc", 32'(bc[0]), 32'd4);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) check($sformatf("rst_async_%0d", i), 32'(observe(i)), 32'h81);
      step();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("rst_quiet_%0d", i), 32'(observe(0)), 32'h81);
      end

      // First transfer after reset has normal latency.
      build_frame(8'hC3, 1, 1'b0, 1'b0);
      apply_vecs(0, "post_rst");
      repeat (5) step();

      check("sb0_drain", 32'(gen_mon[0].exp_q.size()), 32'd0);
      check("sb1_drain", 32'(gen_mon[1].exp_q.size()), 32'd0);
      check("sb2_drain", 32'(gen_mon[2].exp_q.size()), 32'd0);
      check("sb1_frames", 32'(gen_mon[1].frames), 32'd1);
      check("sb2_frames", 32'(gen_mon[2].frames), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
